// File: rtl/keypoint_serializer.sv
// Reads packed keypoints from BRAM after detection completes and emits a framed byte stream:
// 0xA5, count[15:8], count[7:0], two bytes per keypoint (MSB first), 0x5A.
module keypoint_serializer #(
   parameter int DIMENSION    = 64,
   parameter int READ_LATENCY = 2,
   parameter int ADDR_W       = $clog2(DIMENSION * DIMENSION),
   parameter int KEY_W        = 2 * $clog2(DIMENSION) + 1
) (
   input  logic              clk,
   input  logic              rst_in,
   input  logic              start,
   input  logic [ADDR_W-1:0] key_count,
   output logic [ADDR_W-1:0] key_read_addr,
   input  logic [KEY_W-1:0]  key_read_data,
   output logic [7:0]        byte_out,
   output logic              byte_valid,
   input  logic              byte_ready,
   output logic              busy,
   output logic              done
);

   localparam int WAIT_W = $clog2(READ_LATENCY + 2);

   typedef enum logic [3:0] {
      S_IDLE, S_HDR, S_CNT_HI, S_CNT_LO, S_FETCH, S_KEY_HI, S_KEY_LO, S_TRL, S_DONE
   } state_t;

   state_t            state, state_next;
   logic [ADDR_W-1:0] count_q;
   logic [ADDR_W-1:0] idx_q;
   logic [ADDR_W-1:0] idx_next;
   logic [WAIT_W-1:0] wait_q;
   logic [15:0]       key_q;
   logic [15:0]       count16;
   logic              xfer;
   logic              fetch_ready;

   assign count16     = 16'(count_q);
   assign idx_next    = idx_q + ADDR_W'(1);
   assign xfer        = byte_valid && byte_ready;
   assign fetch_ready = (wait_q == WAIT_W'(READ_LATENCY));

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst_in) state <= S_IDLE;
      else        state <= state_next;
   end

   // NOTE: every output gets a default first so no path through the case infers a latch.
   always_comb begin
      state_next = state;
      byte_out   = 8'h00;
      byte_valid = 1'b0;
      busy       = 1'b0;
      done       = 1'b0;
      unique case (state)
         S_IDLE: if (start) state_next = S_HDR;
         S_HDR: begin
            busy = 1'b1; byte_valid = 1'b1; byte_out = 8'hA5;
            if (byte_ready) state_next = S_CNT_HI;
         end
         S_CNT_HI: begin
            busy = 1'b1; byte_valid = 1'b1; byte_out = count16[15:8];
            if (byte_ready) state_next = S_CNT_LO;
         end
         S_CNT_LO: begin
            busy = 1'b1; byte_valid = 1'b1; byte_out = count16[7:0];
            if (byte_ready) state_next = (count_q != '0) ? S_FETCH : S_TRL;
         end
         S_FETCH: begin
            busy = 1'b1;
            if (fetch_ready) state_next = S_KEY_HI;
         end
         S_KEY_HI: begin
            busy = 1'b1; byte_valid = 1'b1; byte_out = key_q[15:8];
            if (byte_ready) state_next = S_KEY_LO;
         end
         S_KEY_LO: begin
            busy = 1'b1; byte_valid = 1'b1; byte_out = key_q[7:0];
            if (byte_ready) state_next = (idx_next == count_q) ? S_TRL : S_FETCH;
         end
         S_TRL: begin
            busy = 1'b1; byte_valid = 1'b1; byte_out = 8'h5A;
            if (byte_ready) state_next = S_DONE;
         end
         S_DONE: begin
            done = 1'b1;
            if (!start) state_next = S_IDLE;
         end
         default: state_next = S_IDLE;
      endcase
   end

   // The read address is loaded on entry to FETCH so it is on the BRAM port for the whole wait.
   always_ff @(posedge clk) begin
      if (rst_in) begin
         count_q       <= '0;
         idx_q         <= '0;
         wait_q        <= '0;
         key_q         <= '0;
         key_read_addr <= '0;
      end else begin
         unique case (state)
            S_IDLE: if (start) begin
               count_q <= key_count;
               idx_q   <= '0;
            end
            S_CNT_LO: if (xfer && count_q != '0) begin
               key_read_addr <= idx_q;
               wait_q        <= '0;
            end
            S_FETCH: begin
               if (fetch_ready) begin
                  key_q  <= 16'(key_read_data);
                  wait_q <= '0;
               end else begin
                  wait_q <= wait_q + WAIT_W'(1);
               end
            end
            S_KEY_LO: if (xfer) begin
               idx_q <= idx_next;
               if (idx_next != count_q) begin
                  key_read_addr <= idx_next;
                  wait_q        <= '0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_keypoint_serializer.sv
// Scoreboard bench for keypoint_serializer: a frame-level model queues expected bytes and a
// monitor pops them on every accepted transfer, also checking stall stability and busy/done.
module tb_keypoint_serializer;

   localparam int ADDR_W = 12;
   localparam int KEY_W  = 13;
   localparam int BIG_N  = 4095;

   logic              clk = 1'b0;
   logic              rst_in;
   logic              start;
   logic [ADDR_W-1:0] key_count;
   logic [ADDR_W-1:0] key_read_addr;
   logic [KEY_W-1:0]  key_read_data;
   logic [7:0]        byte_out;
   logic              byte_valid;
   logic              byte_ready;
   logic              busy;
   logic              done;

   keypoint_serializer dut (
      .clk           (clk),
      .rst_in        (rst_in),
      .start         (start),
      .key_count     (key_count),
      .key_read_addr (key_read_addr),
      .key_read_data (key_read_data),
      .byte_out      (byte_out),
      .byte_valid    (byte_valid),
      .byte_ready    (byte_ready),
      .busy          (busy),
      .done          (done)
   );

   initial forever #5 clk = ~clk;

   // Keypoint BRAM with two-cycle registered read.
   logic [KEY_W-1:0] mem [0:(1<<ADDR_W)-1];
   logic [KEY_W-1:0] rd_q1, rd_q2;
   always @(posedge clk) begin
      rd_q1 <= mem[key_read_addr];
      rd_q2 <= rd_q1;
   end
   assign key_read_data = rd_q2;

   int        vectors     = 0;
   int        miscompares = 0;
   logic [7:0] exp_q[$];
   int        n_popped;
   int        busy_cycles;
   int        addr_changes;
   int        rmode = 0;

   task automatic check(input string name, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Frame model: the byte sequence follows directly from the count and the BRAM contents.
   task automatic build_expected(input int n);
      exp_q.delete();
      exp_q.push_back(8'hA5);
      exp_q.push_back(8'((n >> 8) & 8'hFF));
      exp_q.push_back(8'(n & 8'hFF));
      for (int i = 0; i < n; i++) begin
         int k = int'(mem[i]);
         exp_q.push_back(8'((k >> 8) & 8'hFF));
         exp_q.push_back(8'(k & 8'hFF));
      end
      exp_q.push_back(8'h5A);
   endtask

   // Downstream ready: always high in mode 0, roughly one cycle in three otherwise.
   initial begin
      byte_ready = 1'b1;
      forever begin
         @(posedge clk); #1;
         byte_ready = (rmode == 0) ? 1'b1 : ($urandom_range(0, 2) == 0);
      end
   end

   // Monitor: pops the scoreboard on each transfer; checks stalls and busy/done exclusivity.
   initial begin
      logic       stall_pend = 1'b0;
      logic [7:0] held = 8'h00;
      logic [ADDR_W-1:0] last_addr = '0;
      forever begin
         @(negedge clk);
         if (rst_in) begin
            stall_pend = 1'b0;
         end else begin
            if (busy) busy_cycles++;
            if (key_read_addr != last_addr) addr_changes++;
            last_addr = key_read_addr;
            check("busy_and_done", int'(busy && done), 0);
            if (stall_pend) begin
               check("stall_valid", int'(byte_valid), 1);
               check("stall_data", int'(byte_out), int'(held));
            end
            stall_pend = byte_valid && !byte_ready;
            held       = byte_out;
            if (byte_valid && byte_ready) begin
               if (exp_q.size() == 0) begin
                  vectors++;
                  miscompares++;
                  $display("FAIL extra_byte: got 0x%0h, expected no byte (t=%0t)", byte_out, $time);
               end else begin
                  check("stream_byte", int'(byte_out), int'(exp_q.pop_front()));
                  n_popped++;
               end
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic start_frame(input int n, input int mode);
      rmode        = mode;
      key_count    = ADDR_W'(n);
      build_expected(n);
      n_popped     = 0;
      busy_cycles  = 0;
      addr_changes = 0;
      start        = 1'b1;
   endtask

   task automatic run_frame(input int n, input int mode, input int budget);
      int c;
      start_frame(n, mode);
      c = 0;
      while (!done && c < budget) begin
         tick();
         c++;
      end
      check("frame_done", int'(done), 1);
      check("busy_after_frame", int'(busy), 0);
      check("bytes_left", exp_q.size(), 0);
   endtask

   task automatic drop_start();
      start = 1'b0;
      tick();
      tick();
      check("done_cleared", int'(done), 0);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_valid"}, int'(byte_valid), 0);
      check({tag, "_byte"}, int'(byte_out), 0);
      check({tag, "_busy"}, int'(busy), 0);
      check({tag, "_done"}, int'(done), 0);
      check({tag, "_addr"}, int'(key_read_addr), 0);
   endtask

   initial begin
      int c;
      rst_in    = 1'b1;
      start     = 1'b0;
      key_count = '0;
      n_popped  = 0;
      busy_cycles  = 0;
      addr_changes = 0;
      for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = '0;
      repeat (3) tick();
      check_reset_outputs("reset");
      rst_in = 1'b0;
      tick();

      // Directed frame with known contents and exact cycle count.
      mem[0] = 13'h1ABC; mem[1] = 13'h0001; mem[2] = 13'h0FFF;
      run_frame(3, 0, 200);
      check("cycles_n3", busy_cycles, 4 + 3 * 5);
      drop_start();

      // Empty frame: header and trailer only, no BRAM reads.
      run_frame(0, 0, 200);
      check("cycles_n0", busy_cycles, 4);
      check("addr_idle_n0", addr_changes, 0);
      drop_start();

      // Random backpressure.
      for (int i = 0; i < 2; i++) mem[i] = KEY_W'($urandom);
      run_frame(2, 1, 2000);
      drop_start();

      // Reset while the second keypoint's low byte is presented.
      for (int i = 0; i < 3; i++) mem[i] = KEY_W'($urandom);
      start_frame(3, 0);
      c = 0;
      while (!(n_popped == 6 && byte_valid) && c < 200) begin
         tick();
         c++;
      end
      check("reached_key_lo", n_popped, 6);
      rst_in = 1'b1;
      tick();
      check_reset_outputs("midframe_reset");
      exp_q.delete();
      start = 1'b0;
      tick();
      rst_in = 1'b0;
      tick();
      run_frame(3, 0, 200);
      drop_start();

      // Held start must not retrigger; a fresh rising level sends an identical frame.
      mem[0] = KEY_W'($urandom);
      run_frame(1, 0, 200);
      repeat (200) tick();
      check("held_start_busy", busy_cycles, 4 + 5);
      check("held_start_done", int'(done), 1);
      drop_start();
      run_frame(1, 0, 200);
      drop_start();

      // Randomised frames.
      for (int f = 0; f < 4; f++) begin
         int n = $urandom_range(0, 10);
         for (int i = 0; i < n; i++) mem[i] = KEY_W'($urandom);
         run_frame(n, int'($urandom_range(0, 1)), 5000);
         drop_start();
      end

      // Maximum count with BRAM[i] = i and exact throughput.
      for (int i = 0; i < BIG_N; i++) mem[i] = KEY_W'(i);
      run_frame(BIG_N, 0, 30000);
      check("cycles_max", busy_cycles, 4 + BIG_N * 5);
      drop_start();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
